// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift-register sequencer:
// command opcodes, register mode selects and FSM states.
package usr_pkg;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_SHR      = 2'b01;
    localparam logic [1:0] OP_SHL      = 2'b10;
    localparam logic [1:0] OP_LOAD_SHR = 2'b11;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/usr_shift_sequencer_core.sv
// WIDTH-bit universal shift register: hold, shift right, shift left or
// parallel load, chosen each cycle by sel.
module usr_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] parin,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        case (sel)
            SEL_SHR:  q_d = {ser_in_r, q_q[WIDTH-1:1]};
            SEL_SHL:  q_d = {q_q[WIDTH-2:0], ser_in_l};
            SEL_LOAD: q_d = parin;
            default:  q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command sequencer around usr_core: accepts one load/shift command at a
// time and steps the register mode select until the command completes.
//
// state    | meaning
// ST_IDLE  | ready for a command, register holds
// ST_LOAD  | parallel load of the latched data on the next edge
// ST_SHIFT | shifting, one edge per remaining count
// ST_DONE  | one-cycle completion pulse, register holds
module usr_shift_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Outputs depend only on registered state, never on cmd_* directly.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        sel       = SEL_HOLD;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    cnt_d  = cmd_cnt;
                    data_d = cmd_data;
                    if (cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHR) begin
                        state_d = ST_LOAD;
                    end else if (cmd_cnt != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                sel = SEL_LOAD;
                if (op_q == OP_LOAD_SHR && cnt_q != '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                // LOAD_SHR continues as a right shift, so only SHL goes left.
                sel   = (op_q == OP_SHL) ? SEL_SHL : SEL_SHR;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    usr_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .clr      (clr),
        .sel      (sel),
        .parin    (data_q),
        .ser_in_r (ser_in_r),
        .ser_in_l (ser_in_l),
        .q        (q)
    );

    assign so_r = q[0];
    assign so_l = q[WIDTH-1];

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench for usr_shift_sequencer: directed scenarios plus
// randomized commands checked cycle by cycle against a behavioural model.
module tb_usr_shift_sequencer;
    import usr_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             ser_in_r = 1'b0;
    logic             ser_in_l = 1'b0;
    logic [WIDTH-1:0] q;
    logic             so_r, so_l;
    logic [1:0]       sel;
    logic             busy, done;

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] q_ref = '0;

    // Per-cycle observations of the last executed command (cycle 0 = first
    // cycle after the accept edge) and the serial inputs driven in each cycle.
    logic [1:0]       o_sel[$];
    logic [WIDTH-1:0] o_q[$];
    logic             o_done[$], o_busy[$], o_rdy[$], o_sor[$], o_sol[$];
    logic             h_r[$], h_l[$];

    usr_shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .q(q), .so_r(so_r), .so_l(so_l),
        .sel(sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic exec_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                            input logic [WIDTH-1:0] data, input logic sr,
                            input logic sl, input bit rnd, output bit acc);
        int guard;
        o_sel.delete(); o_q.delete(); o_done.delete(); o_busy.delete();
        o_rdy.delete(); o_sor.delete(); o_sol.delete(); h_r.delete(); h_l.delete();
        acc = 1'b0;
        @(negedge clk);
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (cmd_ready !== 1'b1) return;
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data;
        @(posedge clk); #1;
        acc = 1'b1;
        cmd_valid = 1'b0;
        cmd_op   = 2'($urandom_range(0, 3));
        cmd_cnt  = CNT_W'($urandom_range(0, 7));
        cmd_data = WIDTH'($urandom_range(0, 15));
        for (int k = 0; k < 40; k++) begin
            ser_in_r = rnd ? 1'($urandom_range(0, 1)) : sr;
            ser_in_l = rnd ? 1'($urandom_range(0, 1)) : sl;
            @(negedge clk);
            o_sel.push_back(sel); o_q.push_back(q); o_done.push_back(done);
            o_busy.push_back(busy); o_rdy.push_back(cmd_ready);
            o_sor.push_back(so_r); o_sol.push_back(so_l);
            h_r.push_back(ser_in_r); h_l.push_back(ser_in_l);
            if (done === 1'b1) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        clr = 1'b1;
        #12;
        checks++;
        if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || sel !== SEL_HOLD ||
            cmd_ready !== 1'b1 || so_r !== 1'b0 || so_l !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: q=%b busy=%b done=%b sel=%b rdy=%b so_r=%b so_l=%b required q=0000 busy=0 done=0 sel=00 rdy=1 so=0",
                     q, busy, done, sel, cmd_ready, so_r, so_l);
        end
        @(negedge clk);
        clr = 1'b0;
        q_ref = '0;
    endtask

    task automatic test_load;
        bit acc;
        exec_cmd(OP_LOAD, 3'd5, 4'b1011, 1'b0, 1'b0, 1'b0, acc);
        checks++;
        if (!acc || o_sel.size() != 2) begin
            failures++;
            $display("FAIL load_len: accepted=%0d cycles=%0d required accepted=1 cycles=2", acc, o_sel.size());
        end else begin
            checks++;
            if (o_rdy[0] !== 1'b0 || o_busy[0] !== 1'b1 || o_sel[0] !== SEL_LOAD) begin
                failures++;
                $display("FAIL load_cycle0: rdy=%b busy=%b sel=%b required rdy=0 busy=1 sel=11", o_rdy[0], o_busy[0], o_sel[0]);
            end
            checks++;
            if (o_q[1] !== 4'b1011 || o_done[0] !== 1'b0 || o_done[1] !== 1'b1) begin
                failures++;
                $display("FAIL load_result: q=%b done=%b%b required q=1011 done=01", o_q[1], o_done[0], o_done[1]);
            end
        end
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL load_ready_after: rdy=%b done=%b required rdy=1 done=0", cmd_ready, done);
        end
        q_ref = 4'b1011;
    endtask

    task automatic test_shr;
        bit acc;
        int n_shr, n_done;
        exec_cmd(OP_SHR, 3'd2, 4'b0000, 1'b0, 1'b0, 1'b0, acc);
        n_shr = 0; n_done = 0;
        foreach (o_sel[k]) begin
            if (o_sel[k] === SEL_SHR) n_shr++;
            if (o_done[k] === 1'b1) n_done++;
        end
        checks++;
        if (!acc || o_q.size() != 3 || n_shr != 2 || n_done != 1) begin
            failures++;
            $display("FAIL shr_seq: cycles=%0d shr_cycles=%0d dones=%0d required 3 2 1", o_q.size(), n_shr, n_done);
        end else begin
            checks++;
            if (o_q[1] !== 4'b0101 || o_q[2] !== 4'b0010) begin
                failures++;
                $display("FAIL shr_values: q=%b,%b required 0101,0010", o_q[1], o_q[2]);
            end
        end
        q_ref = 4'b0010;
    endtask

    task automatic test_load_shr;
        bit acc;
        logic [3:0] so_seq;
        exec_cmd(OP_LOAD_SHR, 3'd4, 4'b1011, 1'b0, 1'b0, 1'b0, acc);
        checks++;
        if (!acc || o_q.size() != 6) begin
            failures++;
            $display("FAIL load_shr_len: cycles=%0d required 6", o_q.size());
        end else begin
            so_seq = {o_sor[1], o_sor[2], o_sor[3], o_sor[4]};
            checks++;
            if (so_seq !== 4'b1101 || o_q[5] !== 4'b0000) begin
                failures++;
                $display("FAIL load_shr_serial: so_r seq=%b final q=%b required 1101 0000", so_seq, o_q[5]);
            end
        end
        exec_cmd(OP_SHL, 3'd5, 4'b0000, 1'b0, 1'b1, 1'b0, acc);
        checks++;
        if (!acc || q !== 4'b1111 || o_q.size() != 6) begin
            failures++;
            $display("FAIL shl_flush: q=%b cycles=%0d required q=1111 cycles=6", q, o_q.size());
        end
        q_ref = 4'b1111;
    endtask

    task automatic test_zero_cnt;
        bit acc;
        int n_shl;
        exec_cmd(OP_LOAD, 3'd0, 4'b0110, 1'b0, 1'b0, 1'b0, acc);
        exec_cmd(OP_SHL, 3'd0, 4'b1001, 1'b0, 1'b1, 1'b0, acc);
        n_shl = 0;
        foreach (o_sel[k]) if (o_sel[k] === SEL_SHL) n_shl++;
        checks++;
        if (!acc || o_q.size() != 1 || o_done[0] !== 1'b1 || n_shl != 0 || q !== 4'b0110) begin
            failures++;
            $display("FAIL shl_zero: cycles=%0d shl_cycles=%0d q=%b required cycles=1 done at 0 shl_cycles=0 q=0110",
                     o_q.size(), n_shl, q);
        end
        q_ref = 4'b0110;
    endtask

    task automatic test_back_to_back;
        int n_shl, n_shr, n_done, pre_shl, pre_done;
        bit seen;
        logic [WIDTH-1:0] m;
        n_shl = 0; n_shr = 0; n_done = 0; pre_shl = -1; pre_done = -1; seen = 0;
        ser_in_l = 1'b1; ser_in_r = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SHL; cmd_cnt = 3'd3; cmd_data = 4'b1010;
        @(posedge clk); #1;
        cmd_op = OP_SHR; cmd_cnt = 3'd3;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sel === SEL_SHL) n_shl++;
            if (sel === SEL_SHR) n_shr++;
            if (done === 1'b1) n_done++;
            if (cmd_valid && cmd_ready === 1'b1 && !seen) begin
                pre_shl = n_shl; pre_done = n_done; seen = 1;
            end
            @(posedge clk); #1;
            if (seen) cmd_valid = 1'b0;
            if (n_done == 2) break;
        end
        cmd_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (sel === SEL_SHR) n_shr++;
        end
        checks++;
        if (pre_shl != 3 || pre_done != 1) begin
            failures++;
            $display("FAIL b2b_accept_time: shl_cycles=%0d dones=%0d at accept required 3 1", pre_shl, pre_done);
        end
        m = q_ref;
        for (int i = 0; i < 3; i++) m = WIDTH'((m << 1) | 1);
        for (int i = 0; i < 3; i++) m = m >> 1;
        checks++;
        if (n_shl != 3 || n_shr != 3 || n_done != 2 || q !== m) begin
            failures++;
            $display("FAIL b2b_once: shl=%0d shr=%0d dones=%0d q=%b required 3 3 2 q=%b", n_shl, n_shr, n_done, q, m);
        end
        q_ref = m;
    endtask

    task automatic test_clr_abort;
        bit acc;
        int n_done;
        exec_cmd(OP_LOAD, 3'd0, 4'b1110, 1'b0, 1'b0, 1'b0, acc);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SHR; cmd_cnt = 3'd6; ser_in_r = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        clr = 1'b1;
        #1;
        checks++;
        if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || sel !== SEL_HOLD) begin
            failures++;
            $display("FAIL clr_abort: q=%b busy=%b done=%b sel=%b required 0000 0 0 00", q, busy, done, sel);
        end
        #1;
        clr = 1'b0;
        q_ref = '0;
        n_done = 0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_ready: rdy=%b required 1", cmd_ready);
        end
        repeat (3) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        checks++;
        if (n_done != 0) begin
            failures++;
            $display("FAIL clr_no_done: dones=%0d required 0", n_done);
        end
        exec_cmd(OP_LOAD, 3'd0, 4'b1001, 1'b0, 1'b0, 1'b0, acc);
        checks++;
        if (!acc || o_q.size() != 2 || o_done[1] !== 1'b1 || q !== 4'b1001) begin
            failures++;
            $display("FAIL clr_fresh_load: cycles=%0d q=%b required cycles=2 q=1001", o_q.size(), q);
        end
        q_ref = 4'b1001;
    endtask

    task automatic test_random;
        bit acc;
        logic [1:0]       op, es;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] data, m;
        int ld, n;
        bit right, bad;
        for (int it = 0; it < 40; it++) begin
            op   = 2'($urandom_range(0, 3));
            cnt  = CNT_W'($urandom_range(0, 7));
            data = WIDTH'($urandom_range(0, 15));
            exec_cmd(op, cnt, data, 1'b0, 1'b0, 1'b1, acc);
            ld    = (op == OP_LOAD || op == OP_LOAD_SHR) ? 1 : 0;
            n     = (op == OP_LOAD) ? 0 : int'(cnt);
            right = (op != OP_SHL);
            m     = q_ref;
            checks++;
            if (!acc || o_q.size() != ld + n + 1) begin
                failures++;
                $display("FAIL rand_len it=%0d op=%0d cnt=%0d: cycles=%0d required %0d", it, op, cnt, o_q.size(), ld + n + 1);
                // Resync the model with the register after a length error.
                q_ref = q;
                continue;
            end
            bad = 0;
            for (int k = 0; k < o_q.size(); k++) begin
                es = (k < ld) ? SEL_LOAD : (k < ld + n) ? (right ? SEL_SHR : SEL_SHL) : SEL_HOLD;
                checks++;
                if (o_q[k] !== m || o_sel[k] !== es || o_done[k] !== (k == ld + n) ||
                    o_busy[k] !== 1'b1 || o_rdy[k] !== 1'b0 || o_sor[k] !== m[0] || o_sol[k] !== m[WIDTH-1]) begin
                    failures++;
                    bad = 1;
                    $display("FAIL rand_cycle it=%0d op=%0d cnt=%0d k=%0d: q=%b sel=%b done=%b busy=%b rdy=%b required q=%b sel=%b done=%0d busy=1 rdy=0",
                             it, op, cnt, k, o_q[k], o_sel[k], o_done[k], o_busy[k], o_rdy[k], m, es, (k == ld + n));
                end
                if (k < ld) m = data;
                else if (k < ld + n && right) m = (m >> 1) | (WIDTH'(h_r[k]) << (WIDTH - 1));
                else if (k < ld + n) m = WIDTH'((m << 1) | WIDTH'(h_l[k]));
            end
            checks++;
            if (q !== m) begin
                failures++;
                $display("FAIL rand_final it=%0d: q=%b required %b", it, q, m);
            end
            q_ref = bad ? q : m;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shr();
        test_load_shr();
        test_zero_cnt();
        test_back_to_back();
        test_clr_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
